axi4_lite_lstm_loader: RTL and testbench

AXI4_LITE_LSTM_LOADER -- requirements
Module: axi4_lite_lstm_loader

---
 rtl/axi4_lite_lstm_loader.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_axi4_lite_lstm_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_lstm_loader.sv
// ---------------------------------------------------------------------------
// axi4_lite_lstm_loader
//
// Streams a block of 32-bit words (e.g. LSTM weights) from a valid/ready
// source into an AXI4-Lite slave. It writes one word per AXI transaction and
// keeps at most one transaction outstanding.
//
// Optional feature, selected by the macro LSTM_LOADER_READBACK_EN:
//   Defined   - each written word is read back from the same address and
//               compared with the data that was written.
//   Undefined - the read channel stays idle (arvalid=0, rready=0, araddr=0).
//
// Parameter
//   STRIDE     byte increment of the address between consecutive words
//
// Ports
//   clk, rst   clock; synchronous active-low reset (rst=0 resets)
//   start      command strobe, sampled only in IDLE
//   base_addr  first write address, latched on an accepted start
//   length     word count, latched on an accepted start (0 = empty command)
//   s_data/s_valid/s_ready   input word stream
//   busy       a command is in progress
//   done       one-cycle completion pulse
//   error      sticky for the current command: a non-OKAY response, or a
//              readback mismatch when readback is compiled in
//   aw*/w*/b*  AXI4-Lite write channels (master side)
//   ar*/r*     AXI4-Lite read channels (master side)
//
// Handshake rule on every channel: a beat transfers on a rising edge where
// valid and ready are both 1. Once raised, a valid stays high with its
// payload held stable until that edge, and it does not depend on ready.
// ---------------------------------------------------------------------------
module axi4_lite_lstm_loader #(
  parameter int unsigned STRIDE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] length,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [31:0] STRIDE_W = 32'(STRIDE);
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WRITE = 3'd2,
    WRESP = 3'd3,
    RADDR = 3'd4,
    RDATA = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] addr_q;     // address of the word currently being transferred
  logic [15:0] count_q;    // words still owed, including the current one
  logic [31:0] wdata_q;    // word captured from the stream
  logic        aw_pend_q;  // AW beat not yet accepted
  logic        w_pend_q;   // W beat not yet accepted
  logic        error_q;

  // A channel counts as finished once its beat has been accepted earlier,
  // or is being accepted on this edge.
  logic aw_done_now;
  logic w_done_now;
  logic last_word;

  assign aw_done_now = !aw_pend_q || awready;
  assign w_done_now  = !w_pend_q  || wready;
  // count_q still includes the word whose response is being taken.
  assign last_word   = (count_q == 16'd1);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    bready  = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (length == 16'd0) ? DONE : FETCH;
        end
      end

      FETCH: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (s_valid) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        busy = 1'b1;
        if (aw_done_now && w_done_now) begin
          state_d = WRESP;
        end
      end

      WRESP: begin
        busy   = 1'b1;
        bready = 1'b1;
        if (bvalid) begin
`ifdef LSTM_LOADER_READBACK_EN
          state_d = RADDR;
`else
          state_d = last_word ? DONE : FETCH;
`endif
        end
      end

`ifdef LSTM_LOADER_READBACK_EN
      RADDR: begin
        busy    = 1'b1;
        arvalid = 1'b1;
        if (arready) begin
          state_d = RDATA;
        end
      end

      RDATA: begin
        busy   = 1'b1;
        rready = 1'b1;
        // count_q was already decremented when the write response came back.
        if (rvalid) begin
          state_d = (count_q == 16'd0) ? DONE : FETCH;
        end
      end
`endif

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: address, count, captured word, write-beat tracking, error
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q    <= 32'd0;
      count_q   <= 16'd0;
      wdata_q   <= 32'd0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= base_addr;
            count_q <= length;
            error_q <= 1'b0;
          end
        end

        FETCH: begin
          // Both write beats are launched together from the captured word.
          if (s_valid) begin
            wdata_q   <= s_data;
            aw_pend_q <= 1'b1;
            w_pend_q  <= 1'b1;
          end
        end

        WRITE: begin
          // Each valid drops on its own, the cycle after its own handshake.
          if (aw_pend_q && awready) begin
            aw_pend_q <= 1'b0;
          end
          if (w_pend_q && wready) begin
            w_pend_q <= 1'b0;
          end
        end

        WRESP: begin
          if (bvalid) begin
            // A bad response is recorded but the transfer keeps going.
            if (bresp != RESP_OKAY) begin
              error_q <= 1'b1;
            end
            count_q <= count_q - 16'd1;
`ifndef LSTM_LOADER_READBACK_EN
            addr_q  <= addr_q + STRIDE_W;
`endif
          end
        end

`ifdef LSTM_LOADER_READBACK_EN
        RDATA: begin
          // The address moves on only after readback so that araddr still
          // points at the word that was just written.
          if (rvalid) begin
            if ((rresp != RESP_OKAY) || (rdata != wdata_q)) begin
              error_q <= 1'b1;
            end
            addr_q <= addr_q + STRIDE_W;
          end
        end
`endif

        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Channel outputs
  // -------------------------------------------------------------------------
  assign awaddr  = addr_q;
  assign awprot  = 3'b000;
  assign awvalid = aw_pend_q;
  assign wdata   = wdata_q;
  assign wstrb   = 4'b1111;
  assign wvalid  = w_pend_q;
  assign arprot  = 3'b000;
  assign error   = error_q;

`ifdef LSTM_LOADER_READBACK_EN
  assign araddr = addr_q;
`else
  assign araddr = 32'd0;

  // The read channel inputs are not used when readback is compiled out.
  logic unused_read_inputs;
  assign unused_read_inputs = ^{arready, rvalid, rresp, rdata};
`endif

endmodule

// File: tb/tb_axi4_lite_lstm_loader.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_lstm_loader
//
// Directed bench for axi4_lite_lstm_loader. A small AXI4-Lite slave model
// with per-word AW/W ready delays and per-word write responses records every
// completed write. The driver tasks issue commands and feed the word stream.
// After each command, the recorded writes are compared against an expected
// queue of {address, data} pairs that the bench builds from the command
// parameters.
// ---------------------------------------------------------------------------
module tb_axi4_lite_lstm_loader;

  localparam int STRIDE = 4;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // DUT signals
  // -------------------------------------------------------------------------
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] length = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, busy, done, error;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] rdata;

  axi4_lite_lstm_loader #(.STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .length(length), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .busy(busy), .done(done), .error(error),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // AXI4-Lite slave model
  // -------------------------------------------------------------------------
  int          aw_wait_tab[8];
  int          w_wait_tab[8];
  logic [1:0]  bresp_tab[8];
  logic        rd_corrupt = 1'b0;
  int          wbase = 0;

  int          obs_n = 0;
  logic [31:0] obs_addr[64];
  logic [31:0] obs_data[64];
  int          ar_n = 0;
  logic [31:0] obs_ar[64];
  int          dup_cnt = 0;
  int          aw_cnt = 0;
  int          w_cnt = 0;
  int          cur_i;
  logic        aw_seen = 1'b0;
  logic        w_seen = 1'b0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_data = '0;
  logic [31:0] last_wdata = '0;
  logic        bvalid_r = 1'b0;
  logic [1:0]  bresp_r = '0;
  logic        rvalid_r = 1'b0;
  logic [31:0] rdata_r = '0;

  // Word index within the current command selects the per-word behaviour.
  always_comb cur_i = (obs_n - wbase) & 7;

  assign awready = awvalid && (aw_cnt >= aw_wait_tab[cur_i]);
  assign wready  = wvalid && (w_cnt >= w_wait_tab[cur_i]);
  assign bvalid  = bvalid_r;
  assign bresp   = bresp_r;
  assign arready = arvalid;
  assign rvalid  = rvalid_r;
  assign rdata   = rdata_r;
  assign rresp   = 2'b00;

  always @(posedge clk) begin
    if (!rst) begin
      aw_seen  <= 1'b0;
      w_seen   <= 1'b0;
      aw_cnt   <= 0;
      w_cnt    <= 0;
      bvalid_r <= 1'b0;
      rvalid_r <= 1'b0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (awvalid && awready) begin
        if (aw_seen) dup_cnt <= dup_cnt + 1;
        aw_seen  <= 1'b1;
        cap_addr <= awaddr;
      end
      if (wvalid && wready) begin
        if (w_seen) dup_cnt <= dup_cnt + 1;
        w_seen   <= 1'b1;
        cap_data <= wdata;
      end
      if (aw_seen && w_seen && !bvalid_r) begin
        bvalid_r              <= 1'b1;
        bresp_r               <= bresp_tab[cur_i];
        obs_addr[obs_n & 63]  <= cap_addr;
        obs_data[obs_n & 63]  <= cap_data;
        obs_n                 <= obs_n + 1;
        last_wdata            <= cap_data;
        aw_seen               <= 1'b0;
        w_seen                <= 1'b0;
      end
      if (bvalid_r && bready) bvalid_r <= 1'b0;
      if (arvalid && arready) begin
        obs_ar[ar_n & 63] <= araddr;
        ar_n              <= ar_n + 1;
        rvalid_r          <= 1'b1;
        rdata_r           <= rd_corrupt ? 32'h0000_DEAD : last_wdata;
      end
      if (rvalid_r && rready) rvalid_r <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Monitors (sampled on the falling edge)
  // -------------------------------------------------------------------------
  int done_cnt = 0;
  int aw_vcnt = 0;
  int ar_vcnt = 0;
  int ovl_cnt = 0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (awvalid) aw_vcnt++;
    if (arvalid || rready) ar_vcnt++;
    if (done && busy) ovl_cnt++;
  end

  // -------------------------------------------------------------------------
  // Driver tasks and scoreboard
  // -------------------------------------------------------------------------
  logic [31:0] words[8];
  logic [31:0] src_q[$];
  logic [63:0] exp_q[$];

  task automatic reset_slave_tabs();
    for (int i = 0; i < 8; i++) begin
      aw_wait_tab[i] = 0;
      w_wait_tab[i]  = 0;
      bresp_tab[i]   = 2'b00;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] base,
                         input int len, input logic exp_err,
                         input bit mid_start);
    int cyc;
    bit seen;
    int o0, a0, dn0, dp0;
    logic [63:0] e;
    o0  = obs_n;
    a0  = ar_n;
    dn0 = done_cnt;
    dp0 = dup_cnt;
    wbase = obs_n;
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      src_q.push_back(words[i]);
      exp_q.push_back({base + 32'(i * STRIDE), words[i]});
    end

    @(negedge clk);
    base_addr = base;
    length    = 16'(len);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'(len != 0));
    check({tag, "_errclr"}, 32'(error), 32'd0);
    if (len == 0) check({tag, "_done1"}, 32'(done), 32'd1);

    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      if (done) begin
        seen = 1'b1;
        check({tag, "_err"}, 32'(error), 32'(exp_err));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      end else begin
        if (mid_start && cyc == 3) begin
          start     = 1'b1;
          base_addr = 32'h0000_F000;
          length    = 16'd7;
        end else begin
          start = 1'b0;
        end
        if (src_q.size() != 0) begin
          s_valid = 1'b1;
          s_data  = src_q[0];
        end else begin
          s_valid = 1'b0;
          s_data  = '0;
        end
        if (s_valid && s_ready) void'(src_q.pop_front());
        @(negedge clk);
        cyc++;
      end
    end
    start   = 1'b0;
    s_valid = 1'b0;
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);

    @(negedge clk);
    check({tag, "_errhold"}, 32'(error), 32'(exp_err));
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_done_n"}, 32'(done_cnt - dn0), 32'd1);
    check({tag, "_wcount"}, 32'(obs_n - o0), 32'(len));
    check({tag, "_dup"}, 32'(dup_cnt - dp0), 32'd0);
    for (int i = 0; i < len && (o0 + i) < obs_n; i++) begin
      e = exp_q.pop_front();
      check({tag, "_waddr"}, obs_addr[(o0 + i) & 63], e[63:32]);
      check({tag, "_wdata"}, obs_data[(o0 + i) & 63], e[31:0]);
`ifdef LSTM_LOADER_READBACK_EN
      if ((a0 + i) < ar_n) begin
        check({tag, "_araddr"}, obs_ar[(a0 + i) & 63], e[63:32]);
      end
`endif
    end
`ifdef LSTM_LOADER_READBACK_EN
    check({tag, "_rcount"}, 32'(ar_n - a0), 32'(len));
`else
    check({tag, "_rcount"}, 32'(ar_n - a0), 32'd0);
`endif
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  int av0;
  int cyc;

  initial begin
    reset_slave_tabs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_awaddr", awaddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("awprot", 32'(awprot), 32'd0);
    check("arprot", 32'(arprot), 32'd0);
    check("wstrb", 32'(wstrb), 32'hF);
    rst = 1'b1;
    @(negedge clk);

    // Basic three-word transfer, zero-wait slave.
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    run_cmd("basic", 32'h100, 3, 1'b0, 1'b0);

    // AW accepted 3 cycles before W, then the reverse on the next word.
    aw_wait_tab[0] = 0; w_wait_tab[0] = 3;
    aw_wait_tab[1] = 3; w_wait_tab[1] = 0;
    words[0] = 32'h1111_0001; words[1] = 32'h2222_0002;
    run_cmd("skew", 32'h400, 2, 1'b0, 1'b0);
    reset_slave_tabs();

    // SLVERR on the second of four words: all words written, error sticky.
    bresp_tab[1] = 2'b10;
    words[0] = 32'h10; words[1] = 32'h20; words[2] = 32'h30; words[3] = 32'h40;
    run_cmd("slverr", 32'h800, 4, 1'b1, 1'b0);
    reset_slave_tabs();
    words[0] = 32'h5A5A_5A5A;
    run_cmd("errclr", 32'h900, 1, 1'b0, 1'b0);

    // Empty command: done next cycle, no write address ever offered.
    av0 = aw_vcnt;
    run_cmd("len0", 32'hA00, 0, 1'b0, 1'b0);
    check("len0_noaw", 32'(aw_vcnt - av0), 32'd0);

    // A start pulse while busy must be ignored.
    words[0] = 32'hCAFE_0001; words[1] = 32'hCAFE_0002;
    run_cmd("busy_start", 32'h700, 2, 1'b0, 1'b1);

    // Reset while awvalid waits for awready.
    for (int i = 0; i < 8; i++) aw_wait_tab[i] = 40;
    wbase = obs_n;
    @(negedge clk);
    base_addr = 32'h300; length = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 32'h1234;
    cyc = 0;
    while (!awvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_awvalid_seen", 32'(awvalid), 32'd1);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_awvalid", 32'(awvalid), 32'd0);
    check("rst_mid_wvalid", 32'(wvalid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_error", 32'(error), 32'd0);
    check("rst_mid_bready", 32'(bready), 32'd0);
    check("rst_mid_s_ready", 32'(s_ready), 32'd0);
    check("rst_mid_awaddr", awaddr, 32'd0);
    check("rst_mid_wdata", wdata, 32'd0);
    rst = 1'b1;
    reset_slave_tabs();
    words[0] = 32'h0BAD_F00D; words[1] = 32'h0000_0077;
    run_cmd("after_rst", 32'h200, 2, 1'b0, 1'b0);

`ifdef LSTM_LOADER_READBACK_EN
    rd_corrupt = 1'b1;
    words[0] = 32'h0000_BEEF;
    run_cmd("rb_bad", 32'h500, 1, 1'b1, 1'b0);
    rd_corrupt = 1'b0;
    words[0] = 32'h0000_BEEF; words[1] = 32'h0000_0001;
    run_cmd("rb_ok", 32'h600, 2, 1'b0, 1'b0);
`else
    check("rd_chan_idle", 32'(ar_vcnt), 32'd0);
    check("araddr_zero", araddr, 32'd0);
`endif

    check("done_busy_overlap", 32'(ovl_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
